// File: rtl/up2_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | up2_uart_pkg                                                               |
// | Shared UART types and frame constants for the transmitter and receiver.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package up2_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = DATA_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/up2_uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | up2_uart_tx_if                                                             |
// | Byte producer handshake (data/valid/ready) into the UART transmitter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface up2_uart_tx_if;
  import up2_uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/up2_uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | up2_uart_fifo                                                              |
// | DEPTH x WIDTH synchronous FIFO with wrap-around pointers and fill count.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module up2_uart_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wire              clk,
  input  wire              nRst,
  input  wire              push,
  input  wire [WIDTH-1:0]  push_data,
  input  wire              pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Guarded so a misbehaving caller can never corrupt the pointers.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/up2_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | up2_uart_tx                                                                |
// | 8N1 UART transmitter with a small byte FIFO; frames go out back-to-back.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module up2_uart_tx
  import up2_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 4
) (
  input  wire            clk,
  input  wire            nRst,
  up2_uart_tx_if.slave   bus,
  output logic           tx,
  output logic           busy
);

  localparam int                BAUD_W    = cnt_width(CLKS_PER_BIT);
  localparam int                IDX_W     = cnt_width(DATA_BITS);
  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  BIT_LAST  = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 en_q, en_d;
  logic                 baud_done;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  // en_q keeps ready low until the first edge after reset release.
  assign bus.ready = en_q && !fifo_full;
  assign fifo_push = bus.valid && bus.ready;
  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

  up2_uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .nRst      (nRst),
    .push      (fifo_push),
    .push_data (bus.data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    en_d      = 1'b1;
    fifo_pop  = 1'b0;
    baud_done = (baud_q == BAUD_LAST);

    if (state_q != ST_IDLE) begin
      baud_d = baud_done ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          tx_d     = 1'b0;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (baud_done) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_done) begin
          if (bit_idx_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      ST_STOP: begin
        // A queued byte starts its start bit straight out of the stop bit.
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      en_q      <= en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_up2_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_up2_uart_tx                                                             |
// | Self-checking bench: frame-timeline reference model plus line decoder.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_up2_uart_tx;
  import up2_uart_pkg::*;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * C;

  logic clk  = 1'b0;
  logic nRst = 1'b0;
  logic tx;
  logic busy;

  up2_uart_tx_if bus_if ();

  up2_uart_tx #(
    .CLKS_PER_BIT (C),
    .DEPTH        (DEPTH)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus_if.slave),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus one active frame described by its
  // start-relative cycle count; line level follows from cycle / C.
  logic [7:0] q_m[$];
  bit         act_m = 1'b0;
  int         cyc_m = 0;
  logic [7:0] byte_m = 8'h00;
  bit         en_m = 1'b0;

  logic       cap_valid;
  logic [7:0] cap_data;
  logic       cap_nrst;

  // Line decoder samples the DUT tx at mid-bit.
  bit         dec_on = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_sr = 8'h00;
  logic       prev_tx = 1'b1;
  logic [7:0] rx_log[$];

  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];

  function automatic logic model_tx();
    int idx;
    if (!act_m) return 1'b1;
    idx = cyc_m / C;
    if (idx == 0) return 1'b0;
    if (idx == FRAME / C - 1) return 1'b1;
    return byte_m[idx-1];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cap_valid = bus_if.valid;
      cap_data  = bus_if.data;
      cap_nrst  = nRst;
    end
  end

  initial begin
    int  pre;
    bit  rdy;
    int  k;
    forever begin
      @(negedge clk);
      if ((nRst !== 1'b1) || (cap_nrst !== 1'b1)) begin
        q_m.delete();
        act_m   = 1'b0;
        cyc_m   = 0;
        en_m    = 1'b0;
        dec_on  = 1'b0;
        prev_tx = 1'b1;
      end else begin
        rdy = en_m && (q_m.size() < DEPTH);
        pre = q_m.size();
        if (act_m) begin
          cyc_m++;
          if (cyc_m == FRAME) begin
            if (pre > 0) begin
              byte_m = q_m.pop_front();
              cyc_m  = 0;
            end else begin
              act_m = 1'b0;
            end
          end
        end else if (pre > 0) begin
          byte_m = q_m.pop_front();
          act_m  = 1'b1;
          cyc_m  = 0;
        end
        if (cap_valid && rdy) q_m.push_back(cap_data);
        en_m = 1'b1;
      end

      check1("tx", tx, model_tx());
      check1("ready", bus_if.ready, en_m && (q_m.size() < DEPTH));
      check1("busy", busy, act_m || (q_m.size() != 0));

      if (nRst === 1'b1) begin
        if (!dec_on) begin
          if (prev_tx && !tx) begin
            dec_on  = 1'b1;
            dec_cnt = 0;
          end
        end else begin
          dec_cnt++;
        end
        if (dec_on && (dec_cnt % C == C / 2)) begin
          k = dec_cnt / C;
          if (k == 0) begin
            check1("start_bit", tx, 1'b0);
          end else if (k <= 8) begin
            dec_sr[k-1] = tx;
          end else begin
            check1("stop_bit", tx, 1'b1);
            rx_log.push_back(dec_sr);
            dec_on = 1'b0;
          end
        end
        prev_tx = tx;
      end
    end
  end

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic push_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus_if.data  = b;
    bus_if.valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (bus_if.ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checki("push_accept", int'(ok), 1);
    if (ok) sent_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    bus_if.valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus_if.data = 8'($urandom);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checki("idle_reached", int'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    checki({name, "_count"}, rx_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_log.size(); i++) begin
      check8($sformatf("%s_byte%0d", name, i), rx_log[i], exp[i]);
    end
    rx_log.delete();
    sent_q.delete();
  endtask

  initial begin
    bus_if.valid = 1'b0;
    bus_if.data  = 8'h00;
    nRst         = 1'b0;
    repeat (3) @(posedge clk);
    #2 nRst = 1'b1;
    @(negedge clk);
    check1("ready_before_first_edge", bus_if.ready, 1'b0);
    @(negedge clk);
    check1("ready_after_first_edge", bus_if.ready, 1'b1);

    // Single byte, with hand-computed line levels around the start bit.
    push_byte(8'h55);
    bus_if.valid = 1'b0;
    check1("s1_tx_idle_at_accept", tx, 1'b1);
    check1("s1_busy_at_accept", busy, 1'b1);
    for (int i = 0; i < C; i++) begin
      @(negedge clk);
      check1("s1_start_low", tx, 1'b0);
    end
    @(negedge clk);
    check1("s1_bit0", tx, 1'b1);
    repeat (C) @(negedge clk);
    check1("s1_bit1", tx, 1'b0);
    wait_idle();
    exp_q = {8'h55};
    check_rx("single", exp_q);

    // Back-to-back frames.
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_idle();
    exp_q = {8'hA5, 8'h3C};
    check_rx("b2b", exp_q);

    // Backpressure: ready drops with four queued behind the active frame.
    for (int b = 1; b <= 6; b++) begin
      push_byte(8'(b));
      if (b == 5) check1("s3_ready_full", bus_if.ready, 1'b0);
    end
    wait_idle();
    exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    check_rx("full", exp_q);

    // Boundary data patterns.
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle();
    exp_q = {8'h00, 8'hFF};
    check_rx("boundary", exp_q);

    // Held valid with wandering data while not ready.
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);
    begin
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
        if (bus_if.ready) begin
          ok = 1'b1;
          break;
        end
        bus_if.data  = 8'($urandom);
        bus_if.valid = 1'b1;
        @(negedge clk);
      end
      checki("hold_ready_returned", int'(ok), 1);
      bus_if.data = 8'h5A;
      @(negedge clk);
      bus_if.valid = 1'b0;
    end
    wait_idle();
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h5A};
    check_rx("hold", exp_q);

    // Reset during data bit 3 of 0x0F with two bytes queued.
    push_byte(8'h0F);
    push_byte(8'hAA);
    push_byte(8'hBB);
    bus_if.valid = 1'b0;
    repeat (16) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check1("rst_async_tx", tx, 1'b1);
    check1("rst_async_ready", bus_if.ready, 1'b0);
    check1("rst_async_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #2 nRst = 1'b1;
    repeat (100) @(negedge clk);
    check1("rst_after_busy", busy, 1'b0);
    check1("rst_after_tx", tx, 1'b1);
    checki("rst_no_residual_frame", rx_log.size(), 0);
    rx_log.delete();
    sent_q.delete();

    // Randomized traffic with random gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus_if.valid = 1'b0;
        repeat ($urandom_range(1, 20)) begin
          bus_if.data = 8'($urandom);
          @(negedge clk);
        end
      end
      push_byte(8'($urandom));
    end
    exp_q = sent_q;
    wait_idle();
    check_rx("random", exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
